// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : exec_pkg
//  Purpose : Shared types and constants for the execute stage: ALU operation
//            encoding, operation class, stage FSM states and the branch
//            condition helper.
//  Rev     : 1.0  initial release
// ============================================================================
package exec_pkg;

   localparam int OPW    = 4;
   localparam int CLASSW = 3;

   typedef enum logic [OPW-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9,
      ALU_BEQ  = 4'd10,
      ALU_BNE  = 4'd11,
      ALU_BLT  = 4'd12,
      ALU_BGE  = 4'd13,
      ALU_BLTU = 4'd14,
      ALU_BGEU = 4'd15
   } alu_op_t;

   typedef enum logic [CLASSW-1:0] {
      CLS_RR     = 3'd0,
      CLS_RI     = 3'd1,
      CLS_LOAD   = 3'd2,
      CLS_STORE  = 3'd3,
      CLS_BRANCH = 3'd4,
      CLS_MUL    = 3'd5
   } op_class_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MUL_RUN  = 2'd1,
      MUL_DONE = 2'd2
   } exec_state_t;

   // Branch decision from precomputed equal / signed-less / unsigned-less flags.
   function automatic logic branch_taken(input alu_op_t op, input logic eq,
                                         input logic lt, input logic ltu);
      logic taken;
      taken = 1'b0;
      case (op)
         ALU_BEQ:  taken = eq;
         ALU_BNE:  taken = !eq;
         ALU_BLT:  taken = lt;
         ALU_BGE:  taken = !lt;
         ALU_BLTU: taken = ltu;
         ALU_BGEU: taken = !ltu;
         default:  taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage
`default_nettype wire

// File: rtl/exec_stage_pipe_iter_mul.sv
`default_nettype none
// ============================================================================
//  Module  : iter_mul
//  Purpose : Radix-2 shift-add multiplier, one multiplier bit per cycle.
//            Product is the low XLEN bits (wraps modulo 2^XLEN).
//  Ports   : clk, rst_n (async active-low), start (latch a/b, count=XLEN),
//            abort (stop iterating), a, b (operands),
//            done (last step happens this cycle), product (accumulator).
//  Rev     : 1.0  initial release
// ============================================================================
module iter_mul
   import exec_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] product
);

   localparam int CNTW = $clog2(XLEN + 1);

   logic [CNTW-1:0] count;
   logic [XLEN-1:0] acc;
   logic [XLEN-1:0] mcand;
   logic [XLEN-1:0] mplier;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (abort) begin
         count <= '0;
      end else if (start) begin
         count  <= CNTW'(XLEN);
         acc    <= '0;
         mcand  <= a;
         mplier <= b;
      end else if (count != '0) begin
         if (mplier[0]) begin
            acc <= acc + mcand;
         end
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count - 1'b1;
      end
   end

   // The final step is taken on the edge that ends this cycle; acc is final after it.
   assign done    = (count == CNTW'(1));
   assign product = acc;

endmodule
`default_nettype wire

// File: rtl/exec_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module  : exec_stage_pipe
//  Purpose : Execute stage between register-read and memory: operand
//            forwarding, ALU, branch condition/target, store-address
//            immediate selection, optional iterative multiplier, and a
//            valid/ready EX/MEM result register.
//  Config  : `define EXEC_MUL_EN to build the MUL class on iter_mul; without
//            it MUL is executed as an RR ADD and busy is tied low.
//  Ports   : in_valid/in_ready/in_* decode side, fwd_sel_a/b + fwd_data
//            forwarding, flush, out_valid/out_ready/out_* memory side,
//            busy = multiplier iterating. reset is async active-low.
//  Rev     : 1.0  initial release
// ============================================================================
module exec_stage_pipe
   import exec_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int NUM_FWD = 2,
   parameter int FSEL_W  = $clog2(NUM_FWD + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [31:0]             in_ir,
   input  logic [XLEN-1:0]         in_pc,
   input  logic [XLEN-1:0]         in_a,
   input  logic [XLEN-1:0]         in_b,
   input  logic [XLEN-1:0]         in_imm,
   input  logic [OPW-1:0]          in_op,
   input  logic [CLASSW-1:0]       in_class,
   input  logic [FSEL_W-1:0]       fwd_sel_a,
   input  logic [FSEL_W-1:0]       fwd_sel_b,
   input  logic [NUM_FWD*XLEN-1:0] fwd_data,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_ir,
   output logic [XLEN-1:0]         out_alu,
   output logic [XLEN-1:0]         out_b,
   output logic                    out_cond,
   output logic [XLEN-1:0]         out_target,
   output logic                    busy
);

   localparam int SHW = $clog2(XLEN);

   op_class_t       cls;
   alu_op_t         op;
   exec_state_t     state;
   logic [XLEN-1:0] opa, rs2, opb, st_imm, alu_res, res, target;
   logic            is_branch, cond, out_free, accept, is_mul, ld_single;

   assign cls = op_class_t'(in_class);

`ifdef EXEC_MUL_EN
   assign op     = alu_op_t'(in_op);
   assign is_mul = (cls == CLS_MUL);
`else
   // Without the multiplier, MUL degrades to an RR ADD.
   assign op     = (cls == CLS_MUL) ? ALU_ADD : alu_op_t'(in_op);
   assign is_mul = 1'b0;
`endif

   // Forwarding: select 0 (or anything above NUM_FWD) keeps the register value.
   always_comb begin
      opa = in_a;
      rs2 = in_b;
      for (int k = 0; k < NUM_FWD; k++) begin
         if (fwd_sel_a == FSEL_W'(k + 1)) opa = fwd_data[k*XLEN +: XLEN];
         if (fwd_sel_b == FSEL_W'(k + 1)) rs2 = fwd_data[k*XLEN +: XLEN];
      end
   end

   assign st_imm = {{(XLEN-12){in_ir[31]}}, in_ir[31:25], in_ir[11:7]};

   always_comb begin
      opb = rs2;
      case (cls)
         CLS_RI, CLS_LOAD: opb = in_imm;
         CLS_STORE:        opb = st_imm;
         default:          opb = rs2;
      endcase
   end

   always_comb begin
      alu_res = '0;
      case (op)
         ALU_ADD:  alu_res = opa + opb;
         ALU_SUB:  alu_res = opa - opb;
         ALU_AND:  alu_res = opa & opb;
         ALU_OR:   alu_res = opa | opb;
         ALU_XOR:  alu_res = opa ^ opb;
         ALU_SLL:  alu_res = opa << opb[SHW-1:0];
         ALU_SRL:  alu_res = opa >> opb[SHW-1:0];
         ALU_SRA:  alu_res = $signed(opa) >>> opb[SHW-1:0];
         ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(opa) < $signed(opb))};
         ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (opa < opb)};
         default:  alu_res = '0;
      endcase
   end

   assign is_branch = (cls == CLS_BRANCH);
   assign cond      = is_branch &&
                      branch_taken(op, (opa == rs2), ($signed(opa) < $signed(rs2)), (opa < rs2));
   assign res       = is_branch ? (in_pc + XLEN'(4)) : alu_res;
   assign target    = is_branch ? (in_pc + in_imm) : '0;

   assign out_free  = !out_valid || out_ready;
   assign in_ready  = reset && (state == IDLE) && out_free && !flush;
   assign accept    = in_valid && in_ready;
   assign ld_single = accept && !is_mul;

`ifdef EXEC_MUL_EN
   exec_state_t     state_nx;
   logic            mul_start, mul_done, ld_mul;
   logic [XLEN-1:0] mul_product, mul_b;
   logic [31:0]     mul_ir;

   iter_mul #(.XLEN(XLEN)) u_mul (
      .clk     (clk),
      .rst_n   (reset),
      .start   (mul_start),
      .abort   (flush),
      .a       (opa),
      .b       (rs2),
      .done    (mul_done),
      .product (mul_product)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      mul_start = 1'b0;
      if (flush) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:     if (accept && is_mul) begin
                         state_nx  = MUL_RUN;
                         mul_start = 1'b1;
                      end
            MUL_RUN:  if (mul_done) state_nx = MUL_DONE;
            MUL_DONE: if (out_free) state_nx = IDLE;
            default:  state_nx = IDLE;
         endcase
      end
   end

   // Instruction word and store data travel alongside the product.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mul_ir <= '0;
         mul_b  <= '0;
      end else if (mul_start) begin
         mul_ir <= in_ir;
         mul_b  <= rs2;
      end
   end

   assign ld_mul = (state == MUL_DONE) && out_free && !flush;
   assign busy   = (state == MUL_RUN);
`else
   assign state = IDLE;
   assign busy  = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid  <= 1'b0;
         out_ir     <= '0;
         out_alu    <= '0;
         out_b      <= '0;
         out_cond   <= 1'b0;
         out_target <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (ld_single) begin
         out_valid  <= 1'b1;
         out_ir     <= in_ir;
         out_alu    <= res;
         out_b      <= rs2;
         out_cond   <= cond;
         out_target <= target;
      end
`ifdef EXEC_MUL_EN
      else if (ld_mul) begin
         out_valid  <= 1'b1;
         out_ir     <= mul_ir;
         out_alu    <= mul_product;
         out_b      <= mul_b;
         out_cond   <= 1'b0;
         out_target <= '0;
      end
`endif
      else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_exec_stage_pipe.sv
`timescale 1ns/1ps
`default_nettype none
module tb_exec_stage_pipe;
   import exec_pkg::*;

   localparam int XLEN    = 32;
   localparam int NUM_FWD = 2;
   localparam int FSEL_W  = $clog2(NUM_FWD + 1);
`ifdef EXEC_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic in_valid, in_ready, flush, out_valid, out_ready, out_cond, busy;
   logic [31:0] in_ir, out_ir;
   logic [XLEN-1:0] in_pc, in_a, in_b, in_imm, out_alu, out_b, out_target;
   logic [3:0] in_op;
   logic [2:0] in_class;
   logic [FSEL_W-1:0] fwd_sel_a, fwd_sel_b;
   logic [XLEN-1:0] fwd_arr [NUM_FWD];
   logic [NUM_FWD*XLEN-1:0] fwd_data;

   assign fwd_data = {fwd_arr[1], fwd_arr[0]};

   always #5 clk = ~clk;

   exec_stage_pipe #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .FSEL_W(FSEL_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_ir(in_ir), .in_pc(in_pc), .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
      .in_op(in_op), .in_class(in_class), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
      .fwd_data(fwd_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_ir(out_ir), .out_alu(out_alu), .out_b(out_b), .out_cond(out_cond),
      .out_target(out_target), .busy(busy)
   );

   int checks = 0;
   int failures = 0;

   // Reference model state: the EX/MEM register contents plus multiplier progress.
   bit          mv, mcond, wait_done;
   logic [31:0] mir, malu, mb, mtgt;
   int          busy_left;
   logic [31:0] q_prod, q_ir, q_b;
   // Per-cycle prediction from the presented inputs.
   logic [31:0] pa, pr2, palu, ptgt;
   bit          pcond;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mv = 0; mcond = 0; wait_done = 0; busy_left = 0;
      mir = '0; malu = '0; mb = '0; mtgt = '0;
      q_prod = '0; q_ir = '0; q_b = '0;
   endtask

   function automatic logic [31:0] pick(input logic [FSEL_W-1:0] sel, input logic [31:0] rv);
      if (sel != '0 && int'(sel) <= NUM_FWD) return fwd_arr[int'(sel) - 1];
      return rv;
   endfunction

   // Spec-level evaluation of one instruction from the current inputs.
   task automatic predict();
      logic [31:0] ob;
      logic [4:0]  sh;
      pa = pick(fwd_sel_a, in_a);
      pr2 = pick(fwd_sel_b, in_b);
      case (in_class)
         CLS_RI, CLS_LOAD: ob = in_imm;
         CLS_STORE:        ob = {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
         default:          ob = pr2;
      endcase
      sh = ob[4:0];
      palu = '0; pcond = 0; ptgt = '0;
      if (in_class == CLS_BRANCH) begin
         palu = in_pc + 32'd4;
         ptgt = in_pc + in_imm;
         case (in_op)
            4'd10: pcond = (pa == pr2);
            4'd11: pcond = (pa != pr2);
            4'd12: pcond = ($signed(pa) < $signed(pr2));
            4'd13: pcond = ($signed(pa) >= $signed(pr2));
            4'd14: pcond = (pa < pr2);
            4'd15: pcond = (pa >= pr2);
            default: pcond = 0;
         endcase
      end else if (in_class == CLS_MUL) begin
         palu = MUL_EN ? pa * pr2 : pa + pr2;
      end else begin
         case (in_op)
            4'd0: palu = pa + ob;
            4'd1: palu = pa - ob;
            4'd2: palu = pa & ob;
            4'd3: palu = pa | ob;
            4'd4: palu = pa ^ ob;
            4'd5: palu = pa << sh;
            4'd6: palu = pa >> sh;
            4'd7: palu = $signed(pa) >>> sh;
            4'd8: palu = ($signed(pa) < $signed(ob)) ? 32'd1 : 32'd0;
            4'd9: palu = (pa < ob) ? 32'd1 : 32'd0;
            default: palu = '0;
         endcase
      end
   endtask

   // One clock: called at a negedge with inputs already driven; returns at the next negedge.
   task automatic step();
      bit exp_rdy, acc, ld;
      #1;
      exp_rdy = (busy_left == 0) && !wait_done && (!mv || out_ready) && !flush;
      chk1("in_ready", in_ready, exp_rdy);
      chk1("busy", busy, busy_left != 0);
      acc = in_valid && exp_rdy;
      predict();
      @(posedge clk);
      if (flush) begin
         mv = 0; busy_left = 0; wait_done = 0;
      end else begin
         ld = 0;
         if (wait_done) begin
            if (!mv || out_ready) begin
               ld = 1; wait_done = 0;
               malu = q_prod; mir = q_ir; mb = q_b; mcond = 0; mtgt = '0;
            end
         end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) wait_done = 1;
         end else if (acc) begin
            if (MUL_EN && in_class == CLS_MUL) begin
               busy_left = XLEN; q_prod = palu; q_ir = in_ir; q_b = pr2;
            end else begin
               ld = 1;
               malu = palu; mir = in_ir; mb = pr2; mcond = pcond; mtgt = ptgt;
            end
         end
         if (ld) mv = 1;
         else if (out_ready) mv = 0;
      end
      @(negedge clk);
      chk1("out_valid", out_valid, mv);
      if (mv) begin
         chk("out_ir", out_ir, mir);
         chk("out_alu", out_alu, malu);
         chk("out_b", out_b, mb);
         chk1("out_cond", out_cond, mcond);
         chk("out_target", out_target, mtgt);
      end
   endtask

   task automatic set_idle();
      in_valid = 0; flush = 0; out_ready = 1;
      in_ir = 32'h0000_0013; in_pc = '0; in_a = '0; in_b = '0; in_imm = '0;
      in_op = 4'd0; in_class = 3'd0; fwd_sel_a = '0; fwd_sel_b = '0;
      fwd_arr[0] = '0; fwd_arr[1] = '0;
   endtask

   task automatic check_all_zero(input string tag);
      chk1({tag, "_valid"}, out_valid, 1'b0);
      chk1({tag, "_ready"}, in_ready, 1'b0);
      chk1({tag, "_busy"}, busy, 1'b0);
      chk1({tag, "_cond"}, out_cond, 1'b0);
      chk({tag, "_ir"}, out_ir, 32'h0);
      chk({tag, "_alu"}, out_alu, 32'h0);
      chk({tag, "_b"}, out_b, 32'h0);
      chk({tag, "_tgt"}, out_target, 32'h0);
   endtask

   function automatic logic [31:0] rval();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic rand_inputs();
      int c;
      logic [11:0] t;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      c = int'($urandom_range(0, 5));
      in_class = 3'(c);
      if (c == 4) in_op = 4'($urandom_range(10, 15));
      else        in_op = 4'($urandom_range(0, 9));
      in_ir = $urandom;
      in_pc = $urandom & 32'hFFFF_FFFC;
      in_a  = rval();
      in_b  = rval();
      t = 12'($urandom);
      in_imm = {{20{t[11]}}, t};
      fwd_sel_a = FSEL_W'($urandom_range(0, 3));
      fwd_sel_b = FSEL_W'($urandom_range(0, 3));
      fwd_arr[0] = rval();
      fwd_arr[1] = rval();
   endtask

   initial begin
      int lat, busy_cnt;
      bit seen;
      reset = 0;
      set_idle();
      model_reset();
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1;

      // RR ADD 5 + 7
      in_valid = 1; in_class = 3'(CLS_RR); in_op = 4'(ALU_ADD); in_a = 32'd5; in_b = 32'd7;
      step();
      chk("t1_alu", out_alu, 32'd12);
      chk1("t1_valid", out_valid, 1'b1);
      in_valid = 0;
      step();
      chk1("t1_pulse", out_valid, 1'b0);

      // STORE address through forwarding, immediate {7'h01,5'h04} = 36
      set_idle();
      in_valid = 1; in_class = 3'(CLS_STORE); in_op = 4'(ALU_ADD);
      fwd_sel_a = 2'd2; fwd_arr[1] = 32'h100;
      fwd_sel_b = 2'd1; fwd_arr[0] = 32'hABCD_1234;
      in_ir = {7'h01, 5'd2, 5'd1, 3'b010, 5'h04, 7'b0100011};
      step();
      chk("t2_alu", out_alu, 32'h124);
      chk("t2_b", out_b, 32'hABCD_1234);

      // BLT / BLTU with a = -1, b = 1
      set_idle();
      in_valid = 1; in_class = 3'(CLS_BRANCH); in_op = 4'(ALU_BLT);
      in_a = 32'hFFFF_FFFF; in_b = 32'd1; in_pc = 32'h40; in_imm = 32'h10;
      step();
      chk1("t3_blt_cond", out_cond, 1'b1);
      chk("t3_target", out_target, 32'h50);
      chk("t3_alu", out_alu, 32'h44);
      in_op = 4'(ALU_BLTU);
      step();
      chk1("t3_bltu_cond", out_cond, 1'b0);

      // Back-pressure
      set_idle();
      step();
      out_ready = 0; in_valid = 1; in_class = 3'(CLS_RR); in_op = 4'(ALU_ADD);
      in_a = 32'd1; in_b = 32'd2;
      step();
      chk("t4_first", out_alu, 32'd3);
      in_op = 4'(ALU_SUB); in_a = 32'd10; in_b = 32'd4;
      #1 chk1("t4_blocked", in_ready, 1'b0);
      @(negedge clk);
      step();
      chk("t4_hold", out_alu, 32'd3);
      chk1("t4_hold_valid", out_valid, 1'b1);
      out_ready = 1;
      step();
      chk("t4_second", out_alu, 32'd6);

`ifdef EXEC_MUL_EN
      // MUL 0xFFFFFFFF * 3: latency and busy duration
      set_idle();
      step();
      in_valid = 1; in_class = 3'(CLS_MUL); in_a = 32'hFFFF_FFFF; in_b = 32'd3;
      step();
      in_valid = 0;
      busy_cnt = busy ? 1 : 0;
      lat = 0;
      for (int k = 0; k < 100; k++) begin
         step();
         lat++;
         if (busy) busy_cnt++;
         if (out_valid) break;
      end
      chk("t5_latency", 32'(lat), 32'd33);
      chk("t5_busy_cycles", 32'(busy_cnt), 32'd32);
      chk("t5_product", out_alu, 32'hFFFF_FFFD);

      // Same MUL, flushed after 10 cycles
      step();
      in_valid = 1;
      step();
      in_valid = 0;
      repeat (9) step();
      flush = 1;
      step();
      flush = 0;
      chk1("t5_flush_busy", busy, 1'b0);
      chk1("t5_flush_valid", out_valid, 1'b0);
      seen = 0;
      repeat (40) begin
         step();
         if (out_valid) seen = 1;
      end
      chk1("t5_no_result", seen, 1'b0);

      // Async reset while the multiplier iterates
      in_valid = 1;
      step();
      in_valid = 0;
      repeat (5) step();
`else
      // Async reset while a result is held under back-pressure
      set_idle();
      out_ready = 0; in_valid = 1; in_a = 32'd9; in_b = 32'd9;
      step();
      in_valid = 0;
      step();
`endif
      #2 reset = 0;
      #1 check_all_zero("async_rst");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1;
      set_idle();
      in_valid = 1; in_class = 3'(CLS_RR); in_op = 4'(ALU_ADD); in_a = 32'd20; in_b = 32'd22;
      step();
      chk("t6_add", out_alu, 32'd42);

      // Randomized traffic against the model
      repeat (1500) begin
         rand_inputs();
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/exec_stage_pipe.md
Name: exec_stage_pipe

Overview:
- Parametrised execute stage: operand forwarding, ALU, branch-condition/target resolution, store-address immediate selection, optional iterative multiplier.
- Sits between the decode/register-read stage and the memory stage.
- Result register uses a valid/ready handshake, so the stage stalls and back-pressures instead of being free-running.
- Generalises the single-width, two-source execute stage to XLEN and NUM_FWD, with real stall, flush and multi-cycle behaviour.

Parameters:
XLEN, 32, datapath width (32 or 64); instruction word stays 32 bits
NUM_FWD, 2, number of forwarding sources (e.g. EX/MEM, MEM/WB)
FSEL_W, $clog2(NUM_FWD+1), width of a forwarding select

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage can accept this cycle
in_ir  in  32  instruction word
in_pc  in  XLEN  PC of instruction
in_a  in  XLEN  rs1 register value
in_b  in  XLEN  rs2 register value
in_imm  in  XLEN  sign-extended I-type immediate
in_op  in  4  alu_op_t
in_class  in  3  op_class_t (RR, RI, LOAD, STORE, BRANCH, MUL)
fwd_sel_a  in  FSEL_W  0 = register value, k = fwd_data[k-1]
fwd_sel_b  in  FSEL_W  same encoding for rs2
fwd_data  in  NUM_FWD*XLEN  packed forwarding values, source 0 in LSBs
flush  in  1  kill in-flight and registered instruction
out_valid  out  1  EX/MEM register holds a valid result
out_ready  in  1  memory stage consumes the result
out_ir  out  32  registered instruction word
out_alu  out  XLEN  ALU, address or product result
out_b  out  XLEN  forwarded rs2 (store data)
out_cond  out  1  branch taken
out_target  out  XLEN  branch target
busy  out  1  multiplier iterating

Behaviour:
- Reset (reset low, asynchronous): all outputs zero; FSM to IDLE; in_ready deasserted while reset is low.
- Operand A: fwd_sel_a = 0 selects in_a; otherwise fwd_data[fwd_sel_a-1]. Operand A is also the rs1 value. A select value above NUM_FWD selects the register value.
- Forwarded rs2: same muxing of in_b by fwd_sel_b. Drives out_b for every class.
- ALU operand B by class:
  - RR, BRANCH, MUL: forwarded rs2.
  - RI, LOAD: in_imm.
  - STORE: sign-extended {in_ir[31:25], in_ir[11:7]}.
- BRANCH:
  - alu_op BEQ/BNE/BLT/BGE/BLTU/BGEU computes out_cond (signed or unsigned as encoded).
  - out_target = in_pc + in_imm.
  - out_alu = in_pc + 4.
  - For non-branch classes, out_cond = 0 and out_target = 0.
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush.
  - Output register loads on accept for single-cycle classes; latency is 1 cycle.
  - out_valid clears on out_ready when no new load occurs in that cycle.
  - Outputs hold stable while out_valid && !out_ready.
- FSM states: IDLE, MUL_RUN, MUL_DONE.
  - IDLE to MUL_RUN: a MUL is accepted. Latch operands; count = XLEN; busy = 1.
  - MUL_RUN: radix-2 shift-add, one bit per cycle. Count decrements; at count == 1 go to MUL_DONE.
  - MUL_DONE: load out_alu with the low XLEN bits of the product and assert out_valid, once the output register is free (!out_valid || out_ready). Then return to IDLE. Total latency is XLEN+1 cycles from accept.
- Flush has priority over everything in the same cycle:
  - out_valid = 0.
  - FSM to IDLE; multiplier aborts; busy = 0.
  - No accept that cycle.
- Wrap-around: add, sub and product wrap modulo 2^XLEN. Shift amounts use the low $clog2(XLEN) bits.

Optional Feature:
EXEC_MUL_EN
- Defined: MUL class supported as above; the iterative multiplier sub-module is instantiated.
- Undefined: no multiplier logic; FSM is IDLE only; busy is tied to 0.
  - A MUL-class instruction is treated as RR with alu_op ADD, and out_alu = a + b.

Decomposition:
- Package exec_pkg holds:
  - alu_op_t enum: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - op_class_t enum.
  - exec_state_t enum.
  - Constants OPW = 4 and CLASSW = 3.
- Sub-module iter_mul:
  - Ports: start, a, b, abort, done, product.
  - Owns the counter and shift-add datapath.
  - The stage FSM sequences it.

Test Plan:
1. RR ADD, in_a = 5, in_b = 7, sel = 0/0, out_ready = 1: out_alu = 12 one cycle later; out_valid pulses for 1 cycle.
2. Forwarding: fwd_sel_a = 2, fwd_data[1] = 0x100, STORE, in_ir imm fields {7'h01, 5'h04} = 36: out_alu = 0x124; out_b = forwarded rs2.
3. BRANCH BLT, a = -1, b = 1, pc = 0x40, imm = 0x10: out_cond = 1, out_target = 0x50, out_alu = 0x44. Repeat with BLTU: out_cond = 0.
4. Back-pressure: out_ready = 0 with two back-to-back valid inputs: in_ready = 0 after the first; outputs stable; second accepted the cycle out_ready rises.
5. EXEC_MUL_EN, XLEN = 32, MUL 0xFFFF_FFFF × 3: busy for 32 cycles; out_alu = 0xFFFF_FFFD at 33 cycles. Flush at cycle 10 instead: busy = 0 next cycle; no out_valid.
6. Reset asserted mid-MUL, asynchronously: all outputs 0 immediately; after release, the next ADD completes normally.
